vga_display_engine: RTL and testbench

VGA_DISPLAY_ENGINE -- requirements
Module: vga_display_engine

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_timing.sv | 78 +++++++
 rtl/vga_display_engine.sv | 149 ++++++++++++++
 tb/tb_vga_display_engine.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA display engine shared package: default timing, width helpers,
// colour slicing and the sync bundle carried down the pixel pipeline.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vb;
  } sync_t;

  function automatic int h_total(int a, int fp, int s, int bp);
    return a + fp + s + bp;
  endfunction

  function automatic int v_total(int a, int fp, int s, int bp);
    return a + fp + s + bp;
  endfunction

  // never zero, so a divide-by-one divider still gets a 1-bit counter
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [2:0] rgb_r(logic [7:0] c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb_g(logic [7:0] c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb_b(logic [7:0] c);
    return c[1:0];
  endfunction

  function automatic sync_t sync_idle(logic pol);
    return '{hs: ~pol, vs: ~pol, vb: 1'b0};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, raster counters, raw syncs and frame origin pulse.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0,
  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW = cnt_w(HT),
  localparam int VW = cnt_w(VT)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pe,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          frame_start
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;

  // with CLK_DIV = 1 the counter never leaves 0, so pe stays high
  assign pe     = (div == DW'(CLK_DIV - 1));
  assign h_last = (hc == HW'(HT - 1));
  assign v_last = (vc == VW'(VT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else begin
      div <= pe ? '0 : div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && h_last && v_last;
      if (pe) begin
        if (h_last) begin
          hc <= '0;
          vc <= v_last ? '0 : vc + VW'(1);
        end else begin
          hc <= hc + HW'(1);
        end
      end
    end
  end

  always_comb begin
    hs_raw = ~SYNC_POL;
    vs_raw = ~SYNC_POL;
    if (hc >= HW'(H_ACTIVE + H_FP) &&
        hc <  HW'(H_ACTIVE + H_FP + H_SYNC))
      hs_raw = SYNC_POL;
    if (vc >= VW'(V_ACTIVE + V_FP) &&
        vc <  VW'(V_ACTIVE + V_FP + V_SYNC))
      vs_raw = SYNC_POL;
  end

endmodule

// File: rtl/vga_display_engine.sv
// Layered VGA output: painter compositor, two-tick pixel pipeline
// and a cursor position shadow that only moves at the start of vblank.
module vga_display_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0,
  parameter int RGB_W    = 8,
  parameter int N_LAYERS = 3,
  parameter logic [RGB_W-1:0] KEY      = '0,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [9:0]                mouse_x,
  input  logic [8:0]                mouse_y,
  input  logic                      mouse_we,
  output logic [9:0]                hpos,
  output logic [8:0]                vpos,
  output logic [9:0]                cur_x,
  output logic [8:0]                cur_y,
  output logic [2:0]                red,
  output logic [2:0]                green,
  output logic [1:0]                blue,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vblank,
  output logic                      frame_start
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = cnt_w(HT);
  localparam int VW = cnt_w(VT);

  logic          pe;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          hs_raw;
  logic          vs_raw;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .pe          (pe),
    .hc          (hc),
    .vc          (vc),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start)
  );

  logic active;
  logic vb_raw;
  logic xfer;

  assign active = (hc < HW'(H_ACTIVE)) && (vc < VW'(V_ACTIVE));
  assign vb_raw = (vc >= VW'(V_ACTIVE));
  assign hpos   = active ? 10'(hc) : '0;
  assign vpos   = active ? 9'(vc) : '0;
  assign xfer   = pe && (hc == HW'(HT - 1)) &&
                  (vc == VW'(V_ACTIVE - 1));

  logic [N_LAYERS*RGB_W-1:0] s1_rgb;
  logic [N_LAYERS-1:0]       s1_en;
  logic                      s1_act;
  sync_t                     s1_sync;
  logic [RGB_W-1:0]          comp;
  logic [RGB_W-1:0]          color_q;
  sync_t                     s2_sync;

  // walk from the back so the lowest-index opaque layer wins
  always_comb begin
    comp = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (s1_en[i] && s1_rgb[i*RGB_W +: RGB_W] != KEY)
        comp = s1_rgb[i*RGB_W +: RGB_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb  <= '0;
      s1_en   <= '0;
      s1_act  <= 1'b0;
      s1_sync <= sync_idle(SYNC_POL);
      color_q <= '0;
      s2_sync <= sync_idle(SYNC_POL);
    end else if (pe) begin
      s1_rgb  <= layer_rgb;
      s1_en   <= layer_en;
      s1_act  <= active;
      s1_sync <= '{hs: hs_raw, vs: vs_raw, vb: vb_raw};
      color_q <= s1_act ? comp : '0;
      s2_sync <= s1_sync;
    end
  end

  assign red    = rgb_r(8'(color_q));
  assign green  = rgb_g(8'(color_q));
  assign blue   = rgb_b(8'(color_q));
  assign hsync  = s2_sync.hs;
  assign vsync  = s2_sync.vs;
  assign vblank = s2_sync.vb;

  logic [9:0] pend_x;
  logic [8:0] pend_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x <= '0;
      pend_y <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else begin
      if (mouse_we) begin
        pend_x <= mouse_x;
        pend_y <= mouse_y;
      end
      // a write landing on the transfer edge goes straight through
      if (xfer) begin
        cur_x <= mouse_we ? mouse_x : pend_x;
        cur_y <= mouse_we ? mouse_y : pend_y;
      end
    end
  end

endmodule

// File: tb/tb_vga_display_engine.sv
// Random-stimulus bench for vga_display_engine against a raster model,
// plus a second instance measuring sync timing at 800-wide CLK_DIV=1.
module tb_vga_display_engine;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam bit POL = 1'b0;
  localparam logic [7:0] KEYC = 8'h00;
  localparam logic [7:0] BGC  = 8'h49;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  localparam int B_HT = 800 + 40 + 128 + 88;
  localparam int B_VT = 6 + 1 + 4 + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic [23:0] layer_rgb;
  logic [2:0]  layer_en;
  logic [9:0]  mouse_x;
  logic [8:0]  mouse_y;
  logic        mouse_we;

  logic [9:0] hpos, cur_x;
  logic [8:0] vpos, cur_y;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hsync, vsync, vblank, frame_start;

  logic [9:0] b_hpos, b_cur_x;
  logic [8:0] b_vpos, b_cur_y;
  logic [2:0] b_red, b_green;
  logic [1:0] b_blue;
  logic       b_hsync, b_vsync, b_vblank, b_frame_start;

  always #5 clk = ~clk;

  vga_display_engine #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CLK_DIV  (CD), .SYNC_POL (POL), .RGB_W (8),
    .N_LAYERS (3), .KEY (KEYC), .BG_COLOR (BGC)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .layer_rgb (layer_rgb), .layer_en (layer_en),
    .mouse_x (mouse_x), .mouse_y (mouse_y), .mouse_we (mouse_we),
    .hpos (hpos), .vpos (vpos), .cur_x (cur_x), .cur_y (cur_y),
    .red (red), .green (green), .blue (blue),
    .hsync (hsync), .vsync (vsync), .vblank (vblank),
    .frame_start (frame_start)
  );

  vga_display_engine #(
    .H_ACTIVE (800), .H_FP (40), .H_SYNC (128), .H_BP (88),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (4), .V_BP (2),
    .CLK_DIV  (1), .SYNC_POL (1'b1)
  ) dut_b (
    .clk (clk), .rst_n (rst2_n),
    .layer_rgb (layer_rgb), .layer_en (layer_en),
    .mouse_x (mouse_x), .mouse_y (mouse_y), .mouse_we (mouse_we),
    .hpos (b_hpos), .vpos (b_vpos), .cur_x (b_cur_x), .cur_y (b_cur_y),
    .red (b_red), .green (b_green), .blue (b_blue),
    .hsync (b_hsync), .vsync (b_vsync), .vblank (b_vblank),
    .frame_start (b_frame_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] c;
    logic       hs;
    logic       vs;
    logic       vb;
    logic       act;
  } pix_t;

  // raster model: edges/ticks since reset release, pixel index = ticks % FR
  int         edges, ticks;
  pix_t       q[$];
  bit         fs_exp, fs_watch, done2;
  logic [9:0] m_pend_x, m_cur_x;
  logic [8:0] m_pend_y, m_cur_y;

  function automatic pix_t ref_pix(int p);
    pix_t r;
    int   h, v;
    bit   found;
    h = p % HT;
    v = p / HT;
    r.act = (h < HA) && (v < VA);
    r.c = BGC;
    found = 0;
    for (int i = 0; i < 3; i++) begin
      if (!found && layer_en[i] && layer_rgb[i*8 +: 8] != KEYC) begin
        r.c = layer_rgb[i*8 +: 8];
        found = 1;
      end
    end
    if (!r.act) r.c = 8'h00;
    r.hs = (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
    r.vs = (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
    r.vb = (v >= VA);
    return r;
  endfunction

  task automatic model_reset();
    edges = 0;
    ticks = 0;
    q.delete();
    fs_exp = 0;
    m_pend_x = '0;
    m_pend_y = '0;
    m_cur_x = '0;
    m_cur_y = '0;
  endtask

  task automatic compare_all();
    pix_t e;
    int   p, h, v;
    e = (q.size() == 2) ? q[0] : pix_t'{8'h00, !POL, !POL, 1'b0, 1'b0};
    p = ticks % FR;
    h = p % HT;
    v = p / HT;
    chk("rgb", {red, green, blue}, e.c);
    chk("hsync", hsync, e.hs);
    chk("vsync", vsync, e.vs);
    chk("vblank", vblank, e.vb);
    chk("frame_start", frame_start, fs_exp);
    chk("hpos", hpos, (h < HA && v < VA) ? h : 0);
    chk("vpos", vpos, (h < HA && v < VA) ? v : 0);
    chk("cur_x", cur_x, m_cur_x);
    chk("cur_y", cur_y, m_cur_y);
    if (fs_watch && frame_start) begin
      chk("fs_after_reset_clks", edges, FR * CD);
      fs_watch = 0;
    end
  endtask

  task automatic step();
    logic [9:0] nx;
    logic [8:0] ny;
    @(posedge clk);
    fs_exp = 0;
    if (rst_n) begin
      edges++;
      nx = mouse_we ? mouse_x : m_pend_x;
      ny = mouse_we ? mouse_y : m_pend_y;
      if (edges % CD == 0) begin
        q.push_back(ref_pix(ticks % FR));
        if (q.size() > 2) void'(q.pop_front());
        ticks++;
        if (ticks % FR == 0) fs_exp = 1;
        if (ticks % FR == VA * HT) begin
          m_cur_x = nx;
          m_cur_y = ny;
        end
      end
      m_pend_x = nx;
      m_pend_y = ny;
    end
    #1;
    compare_all();
  endtask

  task automatic prio(input logic [2:0] en, input logic [7:0] want,
                      input string tag);
    int n;
    layer_rgb = {8'h1C, 8'hE0, 8'h00};
    layer_en = en;
    mouse_we = 1'b0;
    repeat (3 * CD) step();
    n = 0;
    while (!(q.size() == 2 && q[0].act) && n < 2 * FR * CD) begin
      step();
      n++;
    end
    chk(tag, {red, green, blue}, want);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    layer_rgb = '0;
    layer_en = '0;
    mouse_x = '0;
    mouse_y = '0;
    mouse_we = 1'b0;
    fs_watch = 0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 3; i++)
        layer_rgb[i*8 +: 8] = $urandom_range(0, 1) ? KEYC : 8'($urandom);
      layer_en = 3'($urandom);
      mouse_we = ($urandom_range(0, 15) == 0);
      mouse_x = 10'($urandom);
      mouse_y = 9'($urandom);
      step();
    end

    prio(3'b111, 8'hE0, "prio_l1");
    n = 0;
    while (!(q.size() == 2 && !q[0].act) && n < 2 * FR * CD) begin
      step();
      n++;
    end
    chk("blank_rgb", {red, green, blue}, 8'h00);
    prio(3'b101, 8'h1C, "prio_l2");
    prio(3'b000, BGC, "prio_bg");

    n = 0;
    while ((ticks % FR) / HT != 2 && n < 2 * FR * CD) begin
      step();
      n++;
    end
    mouse_x = 10'd300;
    mouse_y = 9'd200;
    mouse_we = 1'b1;
    step();
    mouse_we = 1'b0;
    n = 0;
    while (ticks % FR != VA * HT && n < 2 * FR * CD) begin
      step();
      n++;
    end
    chk("xfer_x", cur_x, 300);
    chk("xfer_y", cur_y, 200);

    mouse_x = 10'd9;
    mouse_y = 9'd9;
    mouse_we = 1'b1;
    step();
    mouse_we = 1'b0;
    n = 0;
    while (!((edges + 1) % CD == 0 && (ticks + 1) % FR == VA * HT) &&
           n < 2 * FR * CD) begin
      step();
      n++;
    end
    mouse_x = 10'd5;
    mouse_y = 9'd6;
    mouse_we = 1'b1;
    step();
    mouse_we = 1'b0;
    chk("bypass_x", cur_x, 5);
    chk("bypass_y", cur_y, 6);

    n = 0;
    while ((ticks % FR) / HT != 5 && n < 2 * FR * CD) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_rgb", {red, green, blue}, 8'h00);
    chk("rst_hsync", hsync, !POL);
    chk("rst_vsync", vsync, !POL);
    chk("rst_vblank", vblank, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_cur", {cur_x, cur_y}, 19'd0);
    chk("rst_hpos", hpos, 0);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    fs_watch = 1;
    n = 0;
    while (fs_watch && n < 2 * FR * CD) begin
      step();
      n++;
    end
    if (fs_watch) chk("fs_after_reset_timeout", 0, 1);

    n = 0;
    while (!done2 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (!done2) chk("dut_b_timeout", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    int   n, w;
    time  t0;
    done2 = 0;
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_rst_hsync", b_hsync, 1'b0);
    chk("b_rst_vsync", b_vsync, 1'b0);
    rst2_n = 1'b1;
    t0 = $time;

    n = 0;
    while (!b_hsync && n < 5000) begin @(negedge clk); n++; end
    w = 0;
    while (b_hsync && w < 5000) begin @(negedge clk); w++; end
    chk("b_hsync_high_clks", w, 128);
    n = 0;
    while (!b_hsync && n < 5000) begin @(negedge clk); n++; end
    chk("b_h_total_clks", w + n, B_HT);

    n = 0;
    while (!b_vsync && n < 20000) begin @(negedge clk); n++; end
    w = 0;
    while (b_vsync && w < 20000) begin @(negedge clk); w++; end
    chk("b_vsync_high_clks", w, 4 * B_HT);

    n = 0;
    while (!b_frame_start && n < 20000) begin @(negedge clk); n++; end
    chk("b_frame_clks", int'(($time - t0) / 10), B_HT * B_VT);
    done2 = 1;
  end

endmodule
